histo_frame_scheduler: RTL and testbench

//  Frame-level sequencer for the dual histogram datapath. It decides which sensor frames are

---
 rtl/histo_frame_scheduler.sv | 122 ++++++++++++
 tb/tb_histo_frame_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/histo_frame_scheduler.sv
// histo_frame_scheduler: frame decimation, histogram write gating and post-frame bin sweep
// streaming header, 2^BIN_W bin counts and a checksum trailer over valid/ready.
module histo_frame_scheduler #(
  parameter int BIN_W      = 10,
  parameter int DATA_W     = 24,
  parameter int CLR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        decimate,
  input  logic              frame_valid,
  input  logic              line_valid,
  output logic              pixel_valid_o,
  output logic              histo_clear_o,
  output logic [BIN_W-1:0]  bin_o,
  input  logic [DATA_W-1:0] bin_data_i,
  output logic [31:0]       tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic [15:0]       frame_id_o,
  output logic [15:0]       dropped_o,
  output logic [2:0]        state_o
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARM     = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] HEADER  = 3'd3;
  localparam logic [2:0] READ    = 3'd4;
  localparam logic [2:0] SEND    = 3'd5;
  localparam logic [2:0] TRAILER = 3'd6;
  localparam logic [2:0] CLEAR   = 3'd7;

  logic [2:0]        state;
  logic              fv_q;
  logic              fv_rise;
  logic              accept;
  logic [7:0]        skip;
  logic [7:0]        clr_cnt;
  logic [15:0]       hdr_id;
  logic [DATA_W-1:0] data_q;
  logic [23:0]       checksum;

  assign fv_rise = frame_valid & ~fv_q;
  // The accepted frame's first cycle is still ARM, so gate it in directly to lose no pixel.
  assign accept = (state == ARM) & enable & fv_rise & (skip == 8'd0);
  assign pixel_valid_o = frame_valid & line_valid & ((state == CAPTURE) | accept);
  assign histo_clear_o = state == CLEAR;
  assign busy_o = (state != IDLE) && (state != ARM);
  assign state_o = state;

  always_comb begin
    tx_valid_o = (state == HEADER) || (state == SEND) || (state == TRAILER);
    tx_data_o  = (state == HEADER)  ? {8'hA5, 8'h00, hdr_id} :
                 (state == SEND)    ? 32'(data_q) :
                 (state == TRAILER) ? {8'h5A, checksum} : 32'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fv_q       <= 1'b0;
      skip       <= 8'd0;
      clr_cnt    <= 8'd0;
      hdr_id     <= 16'd0;
      data_q     <= '0;
      checksum   <= 24'd0;
      bin_o      <= '0;
      frame_id_o <= 16'd0;
      dropped_o  <= 16'd0;
    end else begin
      fv_q <= frame_valid;
      if (fv_rise) frame_id_o <= frame_id_o + 16'd1;
      if (fv_rise && busy_o && dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
      case (state)
        IDLE: begin
          skip <= 8'd0;
          if (enable) state <= ARM;
        end
        ARM:
          if (!enable) state <= IDLE;
          else if (fv_rise) begin
            if (skip == 8'd0) begin
              skip   <= decimate;
              hdr_id <= frame_id_o + 16'd1;
              state  <= CAPTURE;
            end else skip <= skip - 8'd1;
          end
        CAPTURE: if (!frame_valid) state <= HEADER;
        HEADER:
          if (tx_ready_i) begin
            bin_o    <= '0;
            checksum <= 24'd0;
            state    <= READ;
          end
        READ: begin
          data_q <= bin_data_i;
          state  <= SEND;
        end
        SEND:
          if (tx_ready_i) begin
            checksum <= checksum + 24'(data_q);
            if (&bin_o) state <= TRAILER;
            else begin
              bin_o <= bin_o + 1'b1;
              state <= READ;
            end
          end
        TRAILER:
          if (tx_ready_i) begin
            clr_cnt <= 8'd0;
            state   <= CLEAR;
          end
        CLEAR:
          if (clr_cnt == 8'(CLR_CYCLES - 1)) state <= enable ? ARM : IDLE;
          else clr_cnt <= clr_cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_histo_frame_scheduler.sv
// tb_histo_frame_scheduler: directed frames against a hand-built sweep model; bins read
// from a synthetic histogram whose content is a fixed function of the bin address.
module tb_histo_frame_scheduler;
  logic        clk = 0;
  logic        reset = 0;
  logic        enable = 0;
  logic [7:0]  decimate = 0;
  logic        frame_valid = 0;
  logic        line_valid = 0;
  logic        pixel_valid_o, histo_clear_o, tx_valid_o, tx_ready_i, busy_o;
  logic [9:0]  bin_o;
  logic [23:0] bin_data_i;
  logic [31:0] tx_data_o;
  logic [15:0] frame_id_o, dropped_o;
  logic [2:0]  state_o;
  logic        rand_mode = 0;
  logic        rnd_bit = 1;

  int total = 0;
  int bad = 0;
  int pix_cnt = 0, clr_cnt = 0, words = 0, sweeps = 0, widx = 0, data_err = 0, stable_err = 0;
  logic [31:0] last_hdr = 0, last_trl = 0, first_data = 0, hold_d = 0;
  logic        hold_v = 0;
  logic [23:0] model_sum;

  histo_frame_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .decimate(decimate),
    .frame_valid(frame_valid), .line_valid(line_valid), .pixel_valid_o(pixel_valid_o),
    .histo_clear_o(histo_clear_o), .bin_o(bin_o), .bin_data_i(bin_data_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .frame_id_o(frame_id_o), .dropped_o(dropped_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] f(input int b);
    return 24'(b * 40961 + 12345);
  endfunction

  assign bin_data_i = f(int'(bin_o));
  assign tx_ready_i = rand_mode ? rnd_bit : 1'b1;

  always @(posedge clk) begin
    #1 rnd_bit = $urandom_range(0, 9) < 3;
  end

  always @(negedge clk) begin
    if (!reset) begin
      widx   <= 0;
      hold_v <= 0;
    end else begin
      if (pixel_valid_o) pix_cnt <= pix_cnt + 1;
      if (histo_clear_o) clr_cnt <= clr_cnt + 1;
      if (hold_v && !(tx_valid_o && tx_data_o == hold_d)) stable_err <= stable_err + 1;
      hold_v <= tx_valid_o && !tx_ready_i;
      hold_d <= tx_data_o;
      if (tx_valid_o && tx_ready_i) begin
        words <= words + 1;
        if (widx == 0) last_hdr <= tx_data_o;
        else if (widx <= 1024) begin
          if (tx_data_o != {8'h00, f(widx - 1)}) data_err <= data_err + 1;
          if (widx == 1) first_data <= tx_data_o;
        end else begin
          last_trl <= tx_data_o;
          sweeps   <= sweeps + 1;
        end
        widx <= (widx == 1025) ? 0 : widx + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    @(negedge clk);
    while (state_o != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", 32'(state_o), 32'(s));
  endtask

  task automatic frame(input int rows, input int cols, input logic exp_pv);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        @(posedge clk);
        #1;
        frame_valid = 1;
        line_valid  = 1;
        if (r == 0 && c == 0) begin
          #1 chk("pv_first", 32'(pixel_valid_o), 32'(exp_pv));
        end
      end
      @(posedge clk);
      #1 line_valid = 0;
    end
    @(posedge clk);
    #1 frame_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int p0, w0, s0, c0, d0;
    model_sum = 0;
    for (int b = 0; b < 1024; b++) model_sum = model_sum + f(b);
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_txv", 32'(tx_valid_o), 0);
    chk("rst_fid", 32'(frame_id_o), 0);
    chk("rst_drop", 32'(dropped_o), 0);
    chk("rst_bin", 32'(bin_o), 0);
    chk("rst_clr", 32'(histo_clear_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    @(posedge clk);
    #1 reset = 1;
    enable = 1;
    repeat (2) @(negedge clk);
    chk("arm", 32'(state_o), 1);

    // T1/T5: single 4x4 frame, full sweep with ready held high
    p0 = pix_cnt; w0 = words; c0 = clr_cnt; s0 = sweeps;
    frame(4, 4, 1);
    wait_state(1, 5000);
    chk("t1_pix", pix_cnt - p0, 16);
    chk("t1_words", words - w0, 1026);
    chk("t1_sweeps", sweeps - s0, 1);
    chk("t1_hdr", last_hdr, 32'hA500_0001);
    chk("t1_trl", last_trl, {8'h5A, model_sum});
    chk("t1_clr", clr_cnt - c0, 4);
    chk("t1_data", data_err, 0);

    // T2: decimate=2 captures frames 1 and 4 of 6
    do_reset();
    decimate = 2;
    s0 = sweeps; p0 = pix_cnt;
    for (int i = 0; i < 6; i++) begin
      frame(4, 4, (i == 0 || i == 3));
      wait_state(1, 5000);
      repeat (3) @(negedge clk);
    end
    chk("t2_sweeps", sweeps - s0, 2);
    chk("t2_pix", pix_cnt - p0, 32);
    chk("t2_hdr", last_hdr, 32'hA500_0004);
    chk("t2_fid", 32'(frame_id_o), 6);
    chk("t2_drop", 32'(dropped_o), 0);

    // T3: second frame arrives during SEND and is dropped
    do_reset();
    decimate = 0;
    s0 = sweeps; p0 = pix_cnt; d0 = data_err;
    frame(4, 4, 1);
    wait_state(5, 200);
    frame(2, 2, 0);
    wait_state(1, 5000);
    chk("t3_drop", 32'(dropped_o), 1);
    chk("t3_sweeps", sweeps - s0, 1);
    chk("t3_pix", pix_cnt - p0, 16);
    chk("t3_hdr", last_hdr, 32'hA500_0001);
    chk("t3_data", data_err - d0, 0);
    chk("t3_fid", 32'(frame_id_o), 2);

    // T4: random backpressure
    rand_mode = 1;
    w0 = words;
    frame(4, 4, 1);
    wait_state(1, 20000);
    rand_mode = 0;
    chk("t4_words", words - w0, 1026);
    chk("t4_stable", stable_err, 0);
    chk("t4_data", data_err, 0);
    chk("t4_hdr", last_hdr, 32'hA500_0003);
    chk("t4_trl", last_trl, {8'h5A, model_sum});

    // T6: async reset in READ at bin 100
    frame(4, 4, 1);
    begin
      int n = 0;
      @(negedge clk);
      while (!(state_o == 3'd4 && bin_o == 10'd100) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("t6_reach", 32'(bin_o), 100);
    end
    reset = 0;
    #1;
    chk("t6_state", 32'(state_o), 0);
    chk("t6_txv", 32'(tx_valid_o), 0);
    chk("t6_txd", tx_data_o, 0);
    chk("t6_bin", 32'(bin_o), 0);
    chk("t6_fid", 32'(frame_id_o), 0);
    chk("t6_drop", 32'(dropped_o), 0);
    chk("t6_busy", 32'(busy_o), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    repeat (3) @(negedge clk);
    s0 = sweeps; d0 = data_err;
    frame(4, 4, 1);
    wait_state(1, 5000);
    chk("t6_sweeps", sweeps - s0, 1);
    chk("t6_first", first_data, {8'h00, f(0)});
    chk("t6_hdr", last_hdr, 32'hA500_0001);
    chk("t6_data", data_err - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
